pulse_swallow_ctrl: RTL and testbench
=====================================

PULSE_SWALLOW_CTRL -- requirements
Module: pulse_swallow_ctrl

Interface
REQ-001 SHALL have parameter W, default 8, width of P/S program values and counters.
REQ-002 SHALL have port clk_in  input  1  prescaler output clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port p_val  input  W  program count P, prescaler cycles per output period.
REQ-005 SHALL have port s_val  input  W  swallow count S, the number of those cycles run at divide-by-3.
REQ-006 SHALL have port load  input  1  capture p_val/s_val into the shadow registers on this edge.
REQ-007 SHALL have port mod  output  1  modulus control to the 2/3 prescaler; 1 = divide-by-3, 0 = divide-by-2.
REQ-008 SHALL have port div_out  output  1  one-clk_in-cycle pulse marking the last prescaler cycle of each output period.

Function
REQ-009 SHALL give a total division ratio of N = 2*P + S input cycles per output period when 1 <= P and S <= P.
REQ-010 SHALL drive mod and div_out from registered state only, with no combinational path from any input.
REQ-011 SHALL implement the states IDLE, SWALLOW and NORMAL.
REQ-012 SHALL maintain an active period counter cnt (W bits, down-counting) and an active swallow counter scnt (W bits).
REQ-013 At period start SHALL load cnt = P-1 and scnt = S_eff, where S_eff = min(S, P).
REQ-014 Each edge in SWALLOW or NORMAL SHALL decrement scnt if nonzero, and SHALL decrement cnt if nonzero.
REQ-015 mod SHALL be 1 iff the state is SWALLOW (scnt != 0), and 0 in NORMAL and IDLE.
REQ-016 div_out SHALL be 1 iff the state is not IDLE and cnt == 0.
REQ-017 Transitions:
- SWALLOW goes to NORMAL when scnt reaches 0 and cnt != 0.
- NORMAL or SWALLOW at cnt == 0 (wrap) starts a new period: SWALLOW if S_eff > 0, else NORMAL.
- IDLE is entered instead whenever the new P == 0.
REQ-018 IDLE SHALL start a period on the edge after the active P becomes nonzero; cnt and scnt stay 0 while idle.
REQ-019 load SHALL write the shadow registers on the edge where it is sampled high.
REQ-020 The shadow registers SHALL transfer to the active P/S only at a wrap edge or while in IDLE, never mid-period.
REQ-021 When load is high on a wrap or IDLE edge, the values on p_val/s_val SHALL be used directly (bypass), as well as being written to the shadow registers.
REQ-022 For P == 1, div_out SHALL remain continuously 1, and mod SHALL be 1 iff S >= 1.
REQ-023 S > P SHALL be clamped silently to S_eff = P, giving every cycle at divide-by-3 (N = 3P).
REQ-024 A period SHALL never be shortened or extended by load; only the following period reflects new values.

Reset
REQ-025 When rst_n is sampled low, the block SHALL enter IDLE and clear cnt, scnt, the active P/S and the shadow P/S to 0.
REQ-026 During and after reset, mod and div_out SHALL be 0 until a load with P >= 1 has been applied.
REQ-027 Reset asserted mid-period SHALL abort the period immediately, with no final div_out pulse.

Structure
REQ-028 The shared package SHALL hold the default width W and the state enumeration (IDLE, SWALLOW, NORMAL).
REQ-029 The sub-module load_down_counter (W-bit, synchronous load, decrement-to-zero hold, zero flag) SHALL be instantiated twice, once for cnt and once for scnt.
REQ-030 The block SHALL connect to the existing 2/3 prescaler with prescaler output to clk_in and mod back to the prescaler mod input.

Verification
REQ-031 A bench SHALL cover: load P=4, S=2 -> mod pattern 1,1,0,0 repeating, div_out high on every 4th cycle, and 10 prescaler-input cycles per period.
REQ-032 A bench SHALL cover: P=5, S=0 -> mod constantly 0, div_out every 5th cycle, N=10.
REQ-033 A bench SHALL cover: P=3, S=7 -> S clamped, mod constantly 1, div_out every 3rd cycle, N=9.
REQ-034 A bench SHALL cover: load P=0 -> the block stays or returns to IDLE after the current period, with mod=0 and div_out=0.
REQ-035 A bench SHALL cover: running P=4, S=1, then load P=6, S=3 at cnt=2 -> the current period completes unchanged, and the next period shows mod 1,1,1,0,0,0.
REQ-036 A bench SHALL cover: rst_n low at cnt=1 during SWALLOW -> on the next edge mod=0, div_out=0 and the block is in IDLE; the block then requires a new load to restart.

Source files
------------

// File: rtl/pulse_swallow_ctrl_pkg.sv
// Shared width default and controller state encoding for the pulse-swallow divider.
package pulse_swallow_ctrl_pkg;

    localparam int PSC_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SWALLOW = 2'd1,
        NORMAL  = 2'd2
    } psc_state_e;

endpackage

// File: rtl/pulse_swallow_ctrl_load_down_counter.sv
// W-bit down counter with synchronous load; holds at zero and flags it.
module load_down_counter
    import pulse_swallow_ctrl_pkg::*;
#(
    parameter int W = PSC_W
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_swallow_ctrl.sv
// Pulse-swallow controller for a 2/3 dual-modulus prescaler: N = 2*P + min(S, P).
module pulse_swallow_ctrl
    import pulse_swallow_ctrl_pkg::*;
#(
    parameter int W = PSC_W
) (
    input  logic         clk_in,
    input  logic         rst_n,
    input  logic [W-1:0] p_val,
    input  logic [W-1:0] s_val,
    input  logic         load,
    output logic         mod,
    output logic         div_out
);

    psc_state_e   state_q, state_d;
    logic [W-1:0] p_act_q, p_act_d;
    logic [W-1:0] s_act_q, s_act_d;
    logic [W-1:0] p_sh_q, s_sh_q;
    logic [W-1:0] p_new, s_new;
    logic [W-1:0] src_p, src_s, s_eff;
    logic [W-1:0] cnt_q, scnt_q;
    logic [W-1:0] cnt_ld_val, scnt_ld_val;
    logic         cnt_zero, scnt_zero;
    logic         ctr_ld, ctr_dec, start;

    // A load coinciding with a wrap or idle edge bypasses the shadow registers.
    assign p_new = load ? p_val : p_sh_q;
    assign s_new = load ? s_val : s_sh_q;

    always_comb begin
        state_d     = state_q;
        p_act_d     = p_act_q;
        s_act_d     = s_act_q;
        src_p       = '0;
        src_s       = '0;
        s_eff       = '0;
        start       = 1'b0;
        ctr_ld      = 1'b0;
        ctr_dec     = 1'b0;
        cnt_ld_val  = '0;
        scnt_ld_val = '0;
        case (state_q)
            IDLE: begin
                if (p_act_q != '0) begin
                    start = 1'b1;
                    src_p = p_act_q;
                    src_s = s_act_q;
                end else begin
                    p_act_d = p_new;
                    s_act_d = s_new;
                end
            end
            SWALLOW, NORMAL: begin
                if (cnt_zero) begin
                    p_act_d = p_new;
                    s_act_d = s_new;
                    if (p_new == '0) begin
                        state_d = IDLE;
                        ctr_ld  = 1'b1;
                    end else begin
                        start = 1'b1;
                        src_p = p_new;
                        src_s = s_new;
                    end
                end else begin
                    ctr_dec = 1'b1;
                    if ((state_q == SWALLOW) && ((scnt_q == W'(1)) || scnt_zero)) begin
                        state_d = NORMAL;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                ctr_ld  = 1'b1;
            end
        endcase
        // Period start: cnt counts P-1 down to the div_out cycle, scnt the divide-by-3 cycles.
        if (start) begin
            s_eff       = (src_s > src_p) ? src_p : src_s;
            ctr_ld      = 1'b1;
            cnt_ld_val  = src_p - W'(1);
            scnt_ld_val = s_eff;
            state_d     = (s_eff != '0) ? SWALLOW : NORMAL;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_act_q <= '0;
            s_act_q <= '0;
            p_sh_q  <= '0;
            s_sh_q  <= '0;
        end else begin
            state_q <= state_d;
            p_act_q <= p_act_d;
            s_act_q <= s_act_d;
            if (load) begin
                p_sh_q <= p_val;
                s_sh_q <= s_val;
            end
        end
    end

    load_down_counter #(.W(W)) u_cnt (
        .clk_i      (clk_in),
        .rst_ni     (rst_n),
        .load_i     (ctr_ld),
        .load_val_i (cnt_ld_val),
        .dec_i      (ctr_dec),
        .cnt_o      (cnt_q),
        .zero_o     (cnt_zero)
    );

    load_down_counter #(.W(W)) u_scnt (
        .clk_i      (clk_in),
        .rst_ni     (rst_n),
        .load_i     (ctr_ld),
        .load_val_i (scnt_ld_val),
        .dec_i      (ctr_dec),
        .cnt_o      (scnt_q),
        .zero_o     (scnt_zero)
    );

    assign mod     = (state_q == SWALLOW);
    assign div_out = (state_q != IDLE) && cnt_zero;

endmodule

// File: tb/tb_pulse_swallow_ctrl.sv
// Scoreboard bench for pulse_swallow_ctrl against a period-position reference model.
module tb_pulse_swallow_ctrl;

    localparam int W = 8;

    logic         clk_in = 1'b0;
    logic         rst_n  = 1'b0;
    logic [W-1:0] p_val  = '0;
    logic [W-1:0] s_val  = '0;
    logic         load   = 1'b0;
    logic         mod;
    logic         div_out;

    pulse_swallow_ctrl #(.W(W)) dut (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .p_val   (p_val),
        .s_val   (s_val),
        .load    (load),
        .mod     (mod),
        .div_out (div_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        bit mod;
        bit div;
        int n;
        bit idle;
    } exp_t;

    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a period is P cycles indexed by pos; first min(S,P) are divide-by-3.
    bit m_run = 0;
    int m_p = 0, m_s = 0, m_pos = 0, m_shp = 0, m_shs = 0;

    function automatic int seff(input int p, input int s);
        return (s > p) ? p : s;
    endfunction

    task automatic step(input bit rst, input bit ld, input int pv, input int sv);
        int   pn, sn;
        exp_t e;
        @(negedge clk_in);
        rst_n = !rst;
        load  = ld;
        p_val = W'(pv);
        s_val = W'(sv);
        if (rst) begin
            m_run = 0; m_p = 0; m_s = 0; m_pos = 0; m_shp = 0; m_shs = 0;
        end else begin
            pn = ld ? pv : m_shp;
            sn = ld ? sv : m_shs;
            if (m_run) begin
                if (m_pos == m_p - 1) begin
                    m_p = pn; m_s = sn; m_pos = 0;
                    if (m_p == 0) m_run = 0;
                end else begin
                    m_pos++;
                end
            end else if (m_p != 0) begin
                m_run = 1; m_pos = 0;
            end else begin
                m_p = pn; m_s = sn;
            end
            if (ld) begin
                m_shp = pv; m_shs = sv;
            end
        end
        e.mod  = m_run && (m_pos < seff(m_p, m_s));
        e.div  = m_run && (m_pos == m_p - 1);
        e.n    = 2 * m_p + seff(m_p, m_s);
        e.idle = !m_run;
        exp_q.push_back(e);
    endtask

    task automatic run_idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(0, 0, 0, 0);
    endtask

    // Monitor: one DUT output pair per clk_in cycle, sampled just after the edge.
    initial begin : monitor
        exp_t e;
        int   acc;
        acc = 0;
        forever begin
            @(posedge clk_in);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (mod !== e.mod) begin
                    n_fail++;
                    $display("FAIL mod @%0t: got %b expected %b", $time, mod, e.mod);
                end
                n_tests++;
                if (div_out !== e.div) begin
                    n_fail++;
                    $display("FAIL div_out @%0t: got %b expected %b", $time, div_out, e.div);
                end
                if (e.idle) begin
                    acc = 0;
                end else begin
                    acc += (mod === 1'b1) ? 3 : 2;
                    if (e.div) begin
                        n_tests++;
                        if (acc != e.n) begin
                            n_fail++;
                            $display("FAIL period_N @%0t: got %0d expected %0d", $time, acc, e.n);
                        end
                        acc = 0;
                    end
                end
            end
        end
    end

    task automatic wait_pos(input int p, input int pos, input string tag);
        int k;
        k = 0;
        while (!(m_run && m_p == p && m_pos == pos) && k < 40) begin
            step(0, 0, 0, 0);
            k++;
        end
        if (!(m_run && m_p == p && m_pos == pos)) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_%s: position %0d not reached within 40 cycles", tag, pos);
        end
    endtask

    initial begin : stimulus
        int r;
        bit rs, ld;
        int pv, sv;

        // Reset held, then idle with no load: outputs must stay low.
        repeat (3) step(1, 0, 0, 0);
        run_idle(4);

        // P=4, S=2: mod 1,1,0,0, N=10.
        step(0, 1, 4, 2);
        run_idle(24);
        // P=5, S=0: mod 0, N=10.
        step(0, 1, 5, 0);
        run_idle(24);
        // P=3, S=7 clamps: mod 1, N=9.
        step(0, 1, 3, 7);
        run_idle(18);
        // P=0: returns to idle after the current period.
        step(0, 1, 0, 0);
        run_idle(12);

        // Mid-period reprogram at cnt=2 takes effect only on the next period.
        step(0, 1, 4, 1);
        wait_pos(4, 1, "cnt2");
        step(0, 1, 6, 3);
        run_idle(20);

        // Reset at cnt=1 in SWALLOW aborts the period; restart needs a new load.
        step(0, 1, 4, 3);
        wait_pos(4, 2, "cnt1");
        step(1, 0, 0, 0);
        run_idle(8);
        step(0, 1, 2, 1);
        run_idle(10);

        // P=1 corner cases.
        step(0, 1, 1, 0);
        run_idle(6);
        step(0, 1, 1, 1);
        run_idle(6);
        step(0, 1, 1, 9);
        run_idle(4);

        // Randomized loads, including bypass on wrap edges, P=0 and resets.
        for (int i = 0; i < 600; i++) begin
            r  = $urandom_range(0, 99);
            rs = (r == 0);
            ld = ($urandom_range(0, 6) == 0);
            pv = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 7);
            sv = $urandom_range(0, 9);
            step(rs, ld, pv, sv);
        end

        repeat (2) @(posedge clk_in);
        #3;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
